// File: rtl/weight_fetch_sequencer.sv
// Weight BRAM sequencer: streams DEPTH words over valid/ready through a 2-entry skid buffer.
// Optional host load path into the BRAM is compiled in with WFETCH_LOAD_EN.
module weight_fetch_sequencer #(
    parameter int unsigned DEPTH = 28,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 16
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          START,
    output logic          BUSY,
    output logic          DONE,
    output logic [AW-1:0] BRAM_ADDR,
    output logic          BRAM_EN,
    output logic          BRAM_WE,
    output logic [DW-1:0] BRAM_DI,
    input  logic [DW-1:0] BRAM_DO,
`ifdef WFETCH_LOAD_EN
    input  logic          LD_VALID,
    input  logic [DW-1:0] LD_DATA,
    output logic          LD_READY,
`endif
    output logic          W_VALID,
    input  logic          W_READY,
    output logic [DW-1:0] W_DATA,
    output logic          W_LAST
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
`ifdef WFETCH_LOAD_EN
        , S_LOAD
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] rd_cnt, out_cnt;
    logic [1:0]    occ;
    logic [DW-1:0] buf0, buf1;
    logic          bram_en_q, bram_we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] di_q;
    logic          busy_q, done_q;
    logic          rd_issue, wr_issue, rd_pend, pop;
    logic [2:0]    inflight;

`ifdef WFETCH_LOAD_EN
    logic [AW-1:0] wr_cnt;
`else
    assign wr_issue  = 1'b0;
    assign bram_we_q = 1'b0;
    assign di_q      = '0;
`endif

    assign rd_pend  = bram_en_q & ~bram_we_q;
    assign W_VALID  = (occ != 2'd0);
    assign W_DATA   = buf0;
    assign W_LAST   = W_VALID & (out_cnt == LAST);
    assign pop      = W_VALID & W_READY;
    // Entries buffered plus the read landing at the next edge, net of this cycle's pop.
    assign inflight = {1'b0, occ} + {2'b0, rd_pend} - {2'b0, pop};

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign BRAM_EN   = bram_en_q;
    assign BRAM_WE   = bram_we_q;
    assign BRAM_ADDR = addr_q;
    assign BRAM_DI   = di_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        rd_issue = 1'b0;
`ifdef WFETCH_LOAD_EN
        wr_issue = 1'b0;
        LD_READY = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (START) state_d = S_FETCH;
`ifdef WFETCH_LOAD_EN
                else if (LD_VALID) state_d = S_LOAD;
`endif
            end
            S_FETCH: begin
                if (inflight < 3'd2) begin
                    rd_issue = 1'b1;
                    if (rd_cnt == LAST) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && W_LAST) state_d = S_DONE;
            end
`ifdef WFETCH_LOAD_EN
            S_LOAD: begin
                LD_READY = 1'b1;
                if (LD_VALID) begin
                    wr_issue = 1'b1;
                    if (wr_cnt == LAST) state_d = S_DONE;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_cnt  <= '0;
            out_cnt <= '0;
`ifdef WFETCH_LOAD_EN
            wr_cnt  <= '0;
`endif
        end else if (state_q == S_IDLE) begin
            rd_cnt  <= '0;
            out_cnt <= '0;
`ifdef WFETCH_LOAD_EN
            wr_cnt  <= '0;
`endif
        end else begin
            if (rd_issue && rd_cnt != LAST) rd_cnt <= rd_cnt + 1'b1;
            if (pop && out_cnt != LAST)     out_cnt <= out_cnt + 1'b1;
`ifdef WFETCH_LOAD_EN
            if (wr_issue && wr_cnt != LAST) wr_cnt <= wr_cnt + 1'b1;
`endif
        end
    end

    // BRAM controls are registered so address/enable are stable well before the falling edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bram_en_q <= 1'b0;
            addr_q    <= '0;
`ifdef WFETCH_LOAD_EN
            bram_we_q <= 1'b0;
            di_q      <= '0;
`endif
        end else begin
            bram_en_q <= rd_issue | wr_issue;
            if (rd_issue) addr_q <= rd_cnt;
`ifdef WFETCH_LOAD_EN
            bram_we_q <= wr_issue;
            if (wr_issue) begin
                addr_q <= wr_cnt;
                di_q   <= LD_DATA;
            end
`endif
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            occ  <= 2'd0;
            buf0 <= '0;
            buf1 <= '0;
        end else begin
            case ({rd_pend, pop})
                2'b10: begin
                    if (occ == 2'd0) buf0 <= BRAM_DO;
                    else             buf1 <= BRAM_DO;
                    occ <= occ + 1'b1;
                end
                2'b01: begin
                    buf0 <= buf1;
                    occ  <= occ - 1'b1;
                end
                2'b11: begin
                    if (occ == 2'd2) begin
                        buf0 <= buf1;
                        buf1 <= BRAM_DO;
                    end else begin
                        buf0 <= BRAM_DO;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_q != S_IDLE) && (state_q != S_DONE);
            done_q <= (state_q == S_DONE);
        end
    end

endmodule

// File: tb/tb_weight_fetch_sequencer.sv
// Directed bench for weight_fetch_sequencer with a falling-edge BRAM model.
// Load-path steps are compiled in when WFETCH_LOAD_EN is defined.
module tb_weight_fetch_sequencer;

    localparam int DEPTH = 28;
    localparam int AW    = 5;
    localparam int DW    = 16;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          START;
    logic          BUSY, DONE;
    logic [AW-1:0] BRAM_ADDR;
    logic          BRAM_EN, BRAM_WE;
    logic [DW-1:0] BRAM_DI;
    logic [DW-1:0] BRAM_DO;
    logic          W_VALID, W_READY, W_LAST;
    logic [DW-1:0] W_DATA;
`ifdef WFETCH_LOAD_EN
    logic          LD_VALID, LD_READY;
    logic [DW-1:0] LD_DATA;
`endif

    logic [DW-1:0] mem [0:31];
    logic          preload;
    int            n_checks = 0;
    int            n_fail   = 0;

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (preload) begin
            for (int k = 0; k < 32; k++) mem[k] <= DW'(k + 1);
        end else if (BRAM_EN) begin
            if (BRAM_WE) mem[BRAM_ADDR] <= BRAM_DI;
            else         BRAM_DO <= mem[BRAM_ADDR];
        end
    end

    weight_fetch_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .START     (START),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .BRAM_ADDR (BRAM_ADDR),
        .BRAM_EN   (BRAM_EN),
        .BRAM_WE   (BRAM_WE),
        .BRAM_DI   (BRAM_DI),
        .BRAM_DO   (BRAM_DO),
`ifdef WFETCH_LOAD_EN
        .LD_VALID  (LD_VALID),
        .LD_DATA   (LD_DATA),
        .LD_READY  (LD_READY),
`endif
        .W_VALID   (W_VALID),
        .W_READY   (W_READY),
        .W_DATA    (W_DATA),
        .W_LAST    (W_LAST)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Called one sample after the START edge; mode 0 ready, 1 toggling, 2 ten-cycle stall, 3 repeat START.
    task automatic run_stream(input int mode, input logic [DW-1:0] base);
        int            beats = 0;
        int            reads = 0;
        logic          stalled = 1'b0;
        logic          finished = 1'b0;
        logic [DW-1:0] held = '0;
        for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
            START = 1'b0;
            case (mode)
                1:       W_READY = (cyc % 2 == 0);
                2:       W_READY = (cyc >= 10);
                3: begin W_READY = 1'b1; START = (cyc == 5); end
                default: W_READY = 1'b1;
            endcase
            if (stalled) begin
                check("stall_valid", W_VALID, 1);
                check("stall_data", W_DATA, held);
            end
            if (BRAM_EN && !BRAM_WE) reads++;
            check("outstanding_le2", (reads - beats <= 2), 1);
            if (mode == 2 && cyc == 9) begin
                check("stall_bram_en", BRAM_EN, 0);
                check("stall_reads", reads, 2);
                check("stall_word", W_DATA, base);
            end
            if (W_VALID && W_READY) begin
                check("beat_data", W_DATA, base + beats);
                check("beat_last", W_LAST, (beats == DEPTH - 1));
                beats++;
            end
`ifdef WFETCH_LOAD_EN
            check("ld_ready_fetch", LD_READY, 0);
`endif
            stalled = W_VALID && !W_READY;
            held    = W_DATA;
            if (DONE) finished = 1'b1;
            step();
        end
        START = 1'b0;
        check("done_seen", finished, 1);
        check("beat_count", beats, DEPTH);
        check("done_single", DONE, 0);
    endtask

    initial begin
        RST_N   = 1'b0;
        START   = 1'b0;
        W_READY = 1'b0;
        preload = 1'b1;
`ifdef WFETCH_LOAD_EN
        LD_VALID = 1'b0;
        LD_DATA  = '0;
`endif
        repeat (3) @(posedge CLK);
        #1;
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_en", BRAM_EN, 0);
        check("rst_we", BRAM_WE, 0);
        check("rst_valid", W_VALID, 0);
        check("rst_last", W_LAST, 0);
        check("rst_addr", BRAM_ADDR, 0);
        check("rst_di", BRAM_DI, 0);
        check("rst_wdata", W_DATA, 0);
        preload = 1'b0;
        RST_N   = 1'b1;
        step();

        // Full-rate fetch with exact cycle timing.
        START   = 1'b1;
        W_READY = 1'b1;
        step();
        START = 1'b0;
        check("e0_busy", BUSY, 0);
        check("e0_en", BRAM_EN, 0);
        step();
        check("e1_busy", BUSY, 1);
        check("e1_en", BRAM_EN, 1);
        check("e1_addr", BRAM_ADDR, 0);
        check("e1_we", BRAM_WE, 0);
        check("e1_valid", W_VALID, 0);
        step();
        for (int k = 1; k <= DEPTH; k++) begin
            check("t1_valid", W_VALID, 1);
            check("t1_data", W_DATA, k);
            check("t1_last", W_LAST, (k == DEPTH));
            check("t1_done_early", DONE, 0);
            step();
        end
        check("t1_valid_end", W_VALID, 0);
        check("t1_done_30", DONE, 0);
        step();
        check("t1_done_31", DONE, 1);
        check("t1_busy_31", BUSY, 0);
        step();
        check("t1_done_32", DONE, 0);

        // Toggling backpressure.
        START = 1'b1;
        step();
        run_stream(1, 16'd1);

        // Ten-cycle stall right after START.
        START = 1'b1;
        step();
        run_stream(2, 16'd1);

        // Reset after 12 beats, then a fresh burst from address 0.
        START   = 1'b1;
        W_READY = 1'b1;
        step();
        START = 1'b0;
        repeat (14) step();
        RST_N = 1'b0;
        #1;
        check("mid_rst_busy", BUSY, 0);
        check("mid_rst_valid", W_VALID, 0);
        check("mid_rst_en", BRAM_EN, 0);
        check("mid_rst_addr", BRAM_ADDR, 0);
        check("mid_rst_wdata", W_DATA, 0);
        check("mid_rst_last", W_LAST, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("mid_rst_done", DONE, 0);
        end
        RST_N = 1'b1;
        step();
        check("post_rst_done", DONE, 0);
        START = 1'b1;
        step();
        run_stream(0, 16'd1);

        // START repeated mid-burst is ignored.
        START = 1'b1;
        step();
        run_stream(3, 16'd1);
        for (int k = 0; k < 3; k++) begin
            check("no_rerun_busy", BUSY, 0);
            check("no_rerun_en", BRAM_EN, 0);
            step();
        end

`ifdef WFETCH_LOAD_EN
        // START wins over LD_VALID in IDLE.
        START    = 1'b1;
        LD_VALID = 1'b1;
        step();
        START    = 1'b0;
        LD_VALID = 1'b0;
        run_stream(0, 16'd1);

        // Host load of 0xA000+k, then fetch it back.
        LD_VALID = 1'b1;
        LD_DATA  = 16'hA000;
        step();
        for (int k = 0; k < DEPTH; k++) begin
            LD_DATA = 16'hA000 + 16'(k);
            check("ld_ready", LD_READY, 1);
            step();
            check("ld_en", BRAM_EN, 1);
            check("ld_we", BRAM_WE, 1);
            check("ld_addr", BRAM_ADDR, k);
            check("ld_di", BRAM_DI, 16'hA000 + 16'(k));
            check("ld_done_early", DONE, 0);
        end
        LD_VALID = 1'b0;
        step();
        check("ld_done", DONE, 1);
        check("ld_ready_done", LD_READY, 0);
        step();
        check("ld_done_once", DONE, 0);
        START = 1'b1;
        step();
        run_stream(0, 16'hA000);
`else
        check("ro_we", BRAM_WE, 0);
        check("ro_di", BRAM_DI, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
